// File: rtl/linebuf_sched_if.sv
// Line-buffer scheduler bus: writer handshake, pixel-reader handshake and both RAM ports.
interface linebuf_sched_if #(
  parameter int unsigned ADDR_W = 7
);
  localparam int unsigned DATA_W = 16;

  logic              wr_req;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              back_full;
  logic              rd_start;
  logic              rd_next;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              swap;
  logic              repeat_line;
  logic              underrun;
  logic              ram_wr;
  logic [ADDR_W:0]   ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_rd;
  logic [ADDR_W:0]   ram_raddr;
  logic [DATA_W-1:0] ram_rdata;

  // Scheduler side
  modport slave (
    input  wr_req, wr_data, rd_start, rd_next, ram_rdata,
    output wr_ready, back_full, rd_data, rd_valid, swap, repeat_line, underrun,
           ram_wr, ram_waddr, ram_wdata, ram_rd, ram_raddr
  );

  // Environment side: command processor, pixel generator and RAM
  modport master (
    output wr_req, wr_data, rd_start, rd_next, ram_rdata,
    input  wr_ready, back_full, rd_data, rd_valid, swap, repeat_line, underrun,
           ram_wr, ram_waddr, ram_wdata, ram_rd, ram_raddr
  );
endinterface

// File: rtl/linebuf_sched.sv
// Ping-pong line-buffer scheduler: writer fills the back bank, reader streams the front bank,
// banks swap at line start only when the back bank holds a complete line.
module linebuf_sched #(
  parameter int unsigned ADDR_W         = 7,
  parameter int unsigned WORDS_PER_LINE = 50
) (
  input  logic            clk,
  input  logic            rst,
  linebuf_sched_if.slave  bus
);
  localparam int unsigned DATA_W = 16;
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(WORDS_PER_LINE - 1);

  localparam logic [0:0] W_FILL = 1'b0;
  localparam logic [0:0] W_FULL = 1'b1;

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_FETCH = 2'd1;
  localparam logic [1:0] R_WAIT  = 2'd2;
  localparam logic [1:0] R_HAVE  = 2'd3;

  logic              front_bank_q, front_bank_d;
  logic [0:0]        wstate_q, wstate_d;
  logic [ADDR_W-1:0] wcount_q, wcount_d;
  logic [1:0]        rstate_q, rstate_d;
  logic [ADDR_W-1:0] rcount_q, rcount_d;
  logic              ram_wr_q, ram_wr_d;
  logic [ADDR_W:0]   ram_waddr_q, ram_waddr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              ram_rd_q, ram_rd_d;
  logic [ADDR_W:0]   ram_raddr_q, ram_raddr_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              swap_q, swap_d;
  logic              repeat_line_q, repeat_line_d;
  logic              underrun_q, underrun_d;
  logic              wr_ready_c;
  logic              wr_xfer_c;

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      front_bank_q  <= 1'b0;
      wstate_q      <= W_FILL;
      wcount_q      <= '0;
      rstate_q      <= R_IDLE;
      rcount_q      <= '0;
      ram_wr_q      <= 1'b0;
      ram_waddr_q   <= '0;
      ram_wdata_q   <= '0;
      ram_rd_q      <= 1'b0;
      ram_raddr_q   <= '0;
      rd_data_q     <= '0;
      rd_valid_q    <= 1'b0;
      swap_q        <= 1'b0;
      repeat_line_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      front_bank_q  <= front_bank_d;
      wstate_q      <= wstate_d;
      wcount_q      <= wcount_d;
      rstate_q      <= rstate_d;
      rcount_q      <= rcount_d;
      ram_wr_q      <= ram_wr_d;
      ram_waddr_q   <= ram_waddr_d;
      ram_wdata_q   <= ram_wdata_d;
      ram_rd_q      <= ram_rd_d;
      ram_raddr_q   <= ram_raddr_d;
      rd_data_q     <= rd_data_d;
      rd_valid_q    <= rd_valid_d;
      swap_q        <= swap_d;
      repeat_line_q <= repeat_line_d;
      underrun_q    <= underrun_d;
    end
  end

  // Writer fill, line-start swap decision and reader sequencing
  always_comb begin
    front_bank_d  = front_bank_q;
    wstate_d      = wstate_q;
    wcount_d      = wcount_q;
    rstate_d      = rstate_q;
    rcount_d      = rcount_q;
    ram_wr_d      = 1'b0;
    ram_waddr_d   = ram_waddr_q;
    ram_wdata_d   = ram_wdata_q;
    ram_rd_d      = 1'b0;
    ram_raddr_d   = ram_raddr_q;
    rd_data_d     = rd_data_q;
    rd_valid_d    = rd_valid_q;
    swap_d        = 1'b0;
    repeat_line_d = 1'b0;
    underrun_d    = 1'b0;

    wr_ready_c = (wstate_q == W_FILL) && !rst;
    wr_xfer_c  = bus.wr_req && wr_ready_c;

    // Write always targets the pre-swap back bank; a swap needs W_FULL so never overlaps a transfer
    if (wr_xfer_c) begin
      ram_wr_d    = 1'b1;
      ram_waddr_d = {~front_bank_q, wcount_q};
      ram_wdata_d = bus.wr_data;
      if (wcount_q == LAST_WORD) begin
        wstate_d = W_FULL;
        wcount_d = '0;
      end else begin
        wcount_d = wcount_q + ADDR_W'(1);
      end
    end

    if (bus.rd_start) begin
      // Swap decision uses the writer state from before any same-cycle transfer
      if (wstate_q == W_FULL) begin
        front_bank_d = ~front_bank_q;
        wstate_d     = W_FILL;
        swap_d       = 1'b1;
      end else begin
        repeat_line_d = 1'b1;
      end
      rcount_d   = '0;
      rd_valid_d = 1'b0;
      rstate_d   = R_FETCH;
    end else begin
      unique case (rstate_q)
        R_FETCH: rstate_d = R_WAIT;
        R_WAIT: begin
          rd_data_d  = bus.ram_rdata;
          rd_valid_d = 1'b1;
          rstate_d   = R_HAVE;
        end
        R_HAVE: begin
          if (bus.rd_next) begin
            rd_valid_d = 1'b0;
            if (rcount_q < LAST_WORD) begin
              rcount_d = rcount_q + ADDR_W'(1);
              rstate_d = R_FETCH;
            end else begin
              rstate_d = R_IDLE;
            end
          end
        end
        default: rstate_d = rstate_q;
      endcase
      if (bus.rd_next && !rd_valid_q) begin
        underrun_d = 1'b1;
      end
    end

    // RAM read is issued in the single cycle the reader sits in R_FETCH
    if (rstate_d == R_FETCH) begin
      ram_rd_d    = 1'b1;
      ram_raddr_d = {front_bank_d, rcount_d};
    end
  end

  assign bus.wr_ready    = wr_ready_c;
  assign bus.back_full   = (wstate_q == W_FULL);
  assign bus.rd_data     = rd_data_q;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.swap        = swap_q;
  assign bus.repeat_line = repeat_line_q;
  assign bus.underrun    = underrun_q;
  assign bus.ram_wr      = ram_wr_q;
  assign bus.ram_waddr   = ram_waddr_q;
  assign bus.ram_wdata   = ram_wdata_q;
  assign bus.ram_rd      = ram_rd_q;
  assign bus.ram_raddr   = ram_raddr_q;
endmodule

// File: tb/tb_linebuf_sched.sv
// Directed bench for linebuf_sched with a behavioural 256x16 RAM.
module tb_linebuf_sched;
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned WPL    = 50;

  logic clk = 1'b0;
  logic rst;
  logic mem_init;
  logic [15:0] mem [0:255];

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  linebuf_sched_if #(.ADDR_W(ADDR_W)) bus ();

  linebuf_sched #(.ADDR_W(ADDR_W), .WORDS_PER_LINE(WPL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // RAM model: one-cycle read latency, bank 0 preloaded with 0xA000+addr
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'hA000 + 16'(i);
    end else begin
      if (bus.ram_wr) mem[bus.ram_waddr] <= bus.ram_wdata;
      if (bus.ram_rd) bus.ram_rdata <= mem[bus.ram_raddr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; mem_init = 1'b1;
    bus.wr_req = 1'b0; bus.wr_data = '0; bus.rd_start = 1'b0; bus.rd_next = 1'b0;
    step; mem_init = 1'b0; step;
    check("rst_wr_ready", 32'(bus.wr_ready), 0);
    rst = 1'b0; #1;
    check("rst_wr_ready_rel", 32'(bus.wr_ready), 1);
    check("rst_back_full", 32'(bus.back_full), 0);
    check("rst_ram_wr", 32'(bus.ram_wr), 0);
    check("rst_ram_rd", 32'(bus.ram_rd), 0);
    check("rst_rd_valid", 32'(bus.rd_valid), 0);
    check("rst_pulses", 32'({bus.swap, bus.repeat_line, bus.underrun}), 0);
    check("rst_rd_data", 32'(bus.rd_data), 0);

    // Fill back bank 1 with 0x0000..0x0031
    bus.wr_req = 1'b1;
    for (int k = 0; k < WPL; k++) begin
      bus.wr_data = 16'(k);
      step;
      check("fill_ram_wr", 32'(bus.ram_wr), 1);
      check("fill_waddr", 32'(bus.ram_waddr), 32'(128 + k));
      check("fill_wdata", 32'(bus.ram_wdata), 32'(k));
    end
    bus.wr_req = 1'b0;
    check("fill_back_full", 32'(bus.back_full), 1);
    check("fill_wr_ready", 32'(bus.wr_ready), 0);
    step;
    check("fill_ram_wr_idle", 32'(bus.ram_wr), 0);

    // Swap path
    bus.rd_start = 1'b1; step; bus.rd_start = 1'b0;
    check("swap_pulse", 32'(bus.swap), 1);
    check("swap_no_repeat", 32'(bus.repeat_line), 0);
    check("swap_ram_rd", 32'(bus.ram_rd), 1);
    check("swap_raddr", 32'(bus.ram_raddr), 32'h80);
    check("swap_back_full", 32'(bus.back_full), 0);
    check("swap_wr_ready", 32'(bus.wr_ready), 1);
    step;
    check("swap_pulse_end", 32'(bus.swap), 0);
    check("swap_rd_valid_early", 32'(bus.rd_valid), 0);
    step;

    // Line read with rd_next on each valid word
    for (int i = 0; i < WPL; i++) begin
      check("line_rd_valid", 32'(bus.rd_valid), 1);
      check("line_rd_data", 32'(bus.rd_data), 32'(i));
      bus.rd_next = 1'b1; step; bus.rd_next = 1'b0;
      check("line_valid_drop", 32'(bus.rd_valid), 0);
      if (i < WPL - 1) begin
        check("line_ram_rd", 32'(bus.ram_rd), 1);
        check("line_raddr", 32'(bus.ram_raddr), 32'(128 + i + 1));
        step; step;
      end else begin
        for (int j = 0; j < 4; j++) begin
          check("line_end_valid", 32'(bus.rd_valid), 0);
          check("line_end_ram_rd", 32'(bus.ram_rd), 0);
          step;
        end
      end
    end

    // Repeat path from a fresh reset: partial fill of 10 words
    rst = 1'b1; step; rst = 1'b0; step;
    bus.wr_req = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bus.wr_data = 16'h0100 + 16'(k);
      step;
      check("part_waddr", 32'(bus.ram_waddr), 32'(128 + k));
    end
    bus.wr_req = 1'b0;
    bus.rd_start = 1'b1; step; bus.rd_start = 1'b0;
    check("rep_pulse", 32'(bus.repeat_line), 1);
    check("rep_no_swap", 32'(bus.swap), 0);
    check("rep_raddr", 32'(bus.ram_raddr), 32'h00);
    check("rep_back_full", 32'(bus.back_full), 0);
    step; step;
    check("rep_rd_valid", 32'(bus.rd_valid), 1);
    check("rep_rd_data", 32'(bus.rd_data), 32'hA000);

    // Resume fill; last transfer coincides with rd_start
    bus.wr_req = 1'b1;
    for (int k = 10; k < WPL; k++) begin
      bus.wr_data = 16'h0100 + 16'(k);
      if (k == WPL - 1) bus.rd_start = 1'b1;
      step;
      bus.rd_start = 1'b0;
      check("resume_waddr", 32'(bus.ram_waddr), 32'(128 + k));
    end
    bus.wr_req = 1'b0;
    check("sim_repeat", 32'(bus.repeat_line), 1);
    check("sim_no_swap", 32'(bus.swap), 0);
    check("sim_back_full", 32'(bus.back_full), 1);
    check("sim_wr_ready", 32'(bus.wr_ready), 0);
    step; step;
    check("sim_rd_data", 32'(bus.rd_data), 32'hA000);
    bus.rd_start = 1'b1; step; bus.rd_start = 1'b0;
    check("sim2_swap", 32'(bus.swap), 1);
    check("sim2_no_repeat", 32'(bus.repeat_line), 0);
    check("sim2_raddr", 32'(bus.ram_raddr), 32'h80);
    check("sim2_back_full", 32'(bus.back_full), 0);
    step; step;
    check("sim2_rd_valid", 32'(bus.rd_valid), 1);
    check("sim2_rd_data", 32'(bus.rd_data), 32'h0100);

    // Underrun: second rd_next while word 1 is still in flight
    bus.rd_next = 1'b1; step;
    check("urun_valid_drop", 32'(bus.rd_valid), 0);
    check("urun_none_yet", 32'(bus.underrun), 0);
    step; bus.rd_next = 1'b0;
    check("urun_pulse", 32'(bus.underrun), 1);
    step;
    check("urun_pulse_end", 32'(bus.underrun), 0);
    check("urun_rd_valid", 32'(bus.rd_valid), 1);
    check("urun_rd_data", 32'(bus.rd_data), 32'h0101);

    // Reset in the middle of a read
    bus.rd_next = 1'b1; step; bus.rd_next = 1'b0;
    rst = 1'b1; step;
    check("mid_rst_rd_valid", 32'(bus.rd_valid), 0);
    check("mid_rst_ram_rd", 32'(bus.ram_rd), 0);
    check("mid_rst_wr_ready", 32'(bus.wr_ready), 0);
    rst = 1'b0; step;
    check("post_rst_wr_ready", 32'(bus.wr_ready), 1);
    check("post_rst_rd_valid", 32'(bus.rd_valid), 0);
    check("post_rst_back_full", 32'(bus.back_full), 0);
    bus.rd_start = 1'b1; step; bus.rd_start = 1'b0;
    check("post_rst_repeat", 32'(bus.repeat_line), 1);
    check("post_rst_raddr", 32'(bus.ram_raddr), 32'h00);
    step; step;
    check("post_rst_rd_data", 32'(bus.rd_data), 32'hA000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/linebuf_sched.md
Name: linebuf_sched

Overview:
- Ping-pong scheduler for the 256x16 line-buffer block RAM. The RAM is split into two banks of 2^ADDR_W words each.
- The command processor fills the back bank while the pixel generator reads the front bank.
- Banks swap at each line start, but only when the back bank is complete. Otherwise the front line is repeated.
- Owns both RAM ports. The RAM is instantiated outside this block.

Parameters:
ADDR_W, 7, word-address width within one bank; RAM address width is ADDR_W+1, with the bank as MSB
WORDS_PER_LINE, 50, 16-pixel words per visible line (800/16); legal range 1..2^ADDR_W

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
wr_req  in  1  writer presents wr_data
wr_data  in  16  pixel word from command processor
wr_ready  out  1  scheduler can accept a word this cycle
back_full  out  1  back bank holds a complete line
rd_start  in  1  one-cycle pulse at line start (pixel generator, back-porch end)
rd_next  in  1  one-cycle pulse: current rd_data consumed
rd_data  out  16  current front-bank word
rd_valid  out  1  rd_data is valid
swap  out  1  one-cycle pulse: banks exchanged
repeat_line  out  1  one-cycle pulse: rd_start with back bank not full
underrun  out  1  one-cycle pulse: rd_next while rd_valid=0
ram_wr  out  1  RAM write clock-enable
ram_waddr  out  ADDR_W+1  RAM write address
ram_wdata  out  16  RAM write data
ram_rd  out  1  RAM read clock-enable
ram_raddr  out  ADDR_W+1  RAM read address
ram_rdata  in  16  RAM read data; valid the cycle after ram_rd

Behaviour:
- Reset (rst=1 at a clk edge):
  - front_bank=0; writer state W_FILL; wcount=0; reader state R_IDLE; rcount=0.
  - Every registered output is 0.
  - wr_ready is forced 0 while rst=1.
- wr_ready = (writer state == W_FILL) and not rst. back_full = (writer state == W_FULL).
- A write transfer occurs in any cycle with wr_req=1 and wr_ready=1. On the next cycle:
  - ram_wr=1, ram_waddr={~front_bank, wcount}, ram_wdata=wr_data.
  - wcount increments.
  - ram_wr is otherwise 0.
- Transfer of word WORDS_PER_LINE-1: the writer enters W_FULL and wcount returns to 0. wr_ready is 0 from the next cycle.
- rd_start:
  - If W_FULL: toggle front_bank, writer returns to W_FILL, swap=1 next cycle.
  - Otherwise: front_bank unchanged, repeat_line=1 next cycle, writer state and wcount untouched.
  - In both cases: rcount=0, rd_valid=0, reader enters R_FETCH.
- Reader states:
  - R_IDLE: no reads.
  - R_FETCH, one cycle: ram_rd=1, ram_raddr={front_bank, rcount}. Go to R_WAIT.
  - R_WAIT, one cycle: capture ram_rdata into rd_data, set rd_valid=1, go to R_HAVE.
  - R_HAVE: on rd_next, rd_valid=0.
    - If rcount < WORDS_PER_LINE-1: rcount+1, go to R_FETCH.
    - Otherwise go to R_IDLE.
- Latency:
  - rd_start at edge N gives rd_valid=1 in cycle N+3, with the new front bank used.
  - rd_next at edge M gives the next word valid in cycle M+3.
- rd_next while rd_valid=0 produces an underrun pulse and is otherwise ignored; no state change.
- Simultaneous events:
  - rd_start and a write transfer in the same cycle: the write is accepted into the pre-swap back bank. The swap decision uses the writer state sampled before that transfer. A transfer that completes the line in that cycle does not swap; back_full rises the next cycle.
  - rd_start in a non-idle reader state aborts the line and restarts from word 0. A pending RAM result is discarded.
  - rd_start together with rd_next: rd_start wins and rd_next is ignored.
- A swap never redirects a pending ram_wr. No transfer is possible in W_FULL, so the last write precedes any swap.
- Address arithmetic is unsigned. wcount and rcount are ADDR_W bits and never exceed WORDS_PER_LINE-1.
- rst mid-line or mid-fill applies the reset values above on the next edge. Partial back-bank data is abandoned.

Test Plan:
- Reset check: after rst, wr_ready=1, all other outputs 0. Write 50 words 0x0000..0x0031 with wr_req held high. Required: ram_waddr 0x80..0xB1, then back_full=1 and wr_ready=0.
- Swap path: continue from the full back bank and pulse rd_start. Required: swap pulse, and ram_raddr=0x80 in the cycle after rd_start. rd_valid=1 with rd_data=0x0000 three cycles after rd_start.
- Line read: with rd_next issued on each rd_valid, read all words 0x0000..0x0031 in order. After the 50th rd_next, rd_valid stays 0 and no further ram_rd occurs.
- Repeat path: write only 10 words, then pulse rd_start. Required: repeat_line pulse, reads from bank 0x00, wcount preserved. The next write goes to 0x8A.
- Simultaneous events: the 50th write transfer coincides with rd_start. Required: repeat_line, no swap, back_full=1 next cycle. A second rd_start then produces a swap.
- Faults: rd_next with rd_valid=0 gives underrun=1 for one cycle. rst asserted mid-read gives rd_valid=0, front_bank=0, and wr_ready=1 the cycle after rst deasserts.
